// File: rtl/float_to_fixed_pipe.sv
// Float-to-fixed converter: IEEE-style binary float in, signed fixed-point out.
// Three-stage pipeline (unpack, align, round/saturate) with AXI-Stream handshakes
// and one global stall that freezes all stages together.
module float_to_fixed_pipe #(
    parameter int unsigned EXP_W  = 11,
    parameter int unsigned MAN_W  = 52,
    parameter int unsigned OUT_W  = 64,
    parameter int unsigned FRAC_W = 0,
    parameter int unsigned ROUND  = 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [EXP_W+MAN_W:0]   s_axis_a_tdata,
    input  logic                   s_axis_a_tvalid,
    output logic                   s_axis_a_tready,
    output logic [OUT_W-1:0]       m_axis_result_tdata,
    output logic [2:0]             m_axis_result_tuser,
    output logic                   m_axis_result_tvalid,
    input  logic                   m_axis_result_tready
);

    localparam int SIG_W  = int'(MAN_W) + 1;           // significand incl. hidden bit
    localparam int OUT_I  = int'(OUT_W);
    localparam int FRAC_I = int'(FRAC_W);
    localparam int MAN_I  = int'(MAN_W);
    localparam int BIAS   = int'((1 << (EXP_W - 1)) - 1);
    localparam int AW     = OUT_I + SIG_W;              // aligned magnitude, room for overflow
    localparam int EXT_W  = 2 * SIG_W + 1;              // {sig, guard, sticky field}
    localparam int SH_W   = int'(EXP_W) + $clog2(OUT_W + MAN_W + 1) + 1;

    localparam logic [OUT_W:0]   MAX_POS = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0]   MIN_MAG = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {ClsFinite, ClsInf, ClsNan} cls_e;

    logic advance;

    // Stage 1 registers
    logic                    v1_q;
    logic                    sign1_q, sign1_d;
    cls_e                    cls1_q, cls1_d;
    logic                    zero1_q, zero1_d;
    logic                    sub_nz1_q, sub_nz1_d;
    logic [SIG_W-1:0]        sig1_q, sig1_d;
    logic signed [SH_W-1:0]  shift1_q, shift1_d;

    // Stage 2 registers
    logic                    v2_q;
    logic                    sign2_q;
    cls_e                    cls2_q;
    logic [OUT_W-1:0]        mag2_q, mag2_d;
    logic                    guard2_q, guard2_d;
    logic                    sticky2_q, sticky2_d;
    logic                    pre_ovf2_q, pre_ovf2_d;

    // Stage 3 / output registers
    logic                    tvalid_q;
    logic [OUT_W-1:0]        tdata_q, res_data;
    logic [2:0]              tuser_q, res_user;

    logic [EXP_W-1:0]        exp_w;
    logic [MAN_W-1:0]        man_w;
    int                      sh_int, rs, ls;
    logic [EXT_W-1:0]        ext_r;
    logic [AW-1:0]           mag_full;
    logic                    inc;
    logic [OUT_W:0]          sum;
    logic                    ovf_mag;

    assign advance              = m_axis_result_tready | ~tvalid_q;
    assign s_axis_a_tready      = advance;
    assign m_axis_result_tvalid = tvalid_q;
    assign m_axis_result_tdata  = tdata_q;
    assign m_axis_result_tuser  = tuser_q;

    // S1: split fields, classify, and compute the signed alignment shift
    always_comb begin
        sign1_d   = s_axis_a_tdata[EXP_W+MAN_W];
        exp_w     = s_axis_a_tdata[EXP_W+MAN_W-1:MAN_W];
        man_w     = s_axis_a_tdata[MAN_W-1:0];
        cls1_d    = ClsFinite;
        zero1_d   = 1'b0;
        sub_nz1_d = 1'b0;
        sig1_d    = {1'b1, man_w};
        shift1_d  = SH_W'(int'(exp_w) - BIAS + FRAC_I - MAN_I);
        if (exp_w == '0) begin
            // Zero and subnormals both land on 0; a nonzero fraction is lost precision
            zero1_d   = 1'b1;
            sub_nz1_d = |man_w;
        end else if (&exp_w) begin
            cls1_d = (man_w == '0) ? ClsInf : ClsNan;
        end
    end

    // S2: barrel-shift the significand, keeping guard and sticky on right shifts
    always_comb begin
        sh_int    = int'(shift1_q);
        rs        = 0;
        ls        = 0;
        ext_r     = '0;
        mag_full  = '0;
        guard2_d  = 1'b0;
        sticky2_d = 1'b0;
        if (sh_int < 0) begin
            // Shifting past SIG_W+1 changes nothing more: guard 0, everything sticky
            rs        = (-sh_int > SIG_W + 1) ? SIG_W + 1 : -sh_int;
            ext_r     = {sig1_q, {(SIG_W+1){1'b0}}} >> rs;
            mag_full  = AW'(ext_r[EXT_W-1 -: SIG_W]);
            guard2_d  = ext_r[SIG_W];
            sticky2_d = |ext_r[SIG_W-1:0];
        end else begin
            // Clamping at OUT_W still pushes the hidden bit into the overflow field
            ls       = (sh_int > OUT_I) ? OUT_I : sh_int;
            mag_full = AW'(sig1_q) << ls;
        end
        if (zero1_q) begin
            mag_full  = '0;
            guard2_d  = 1'b0;
            sticky2_d = sub_nz1_q;
        end
        pre_ovf2_d = |mag_full[AW-1:OUT_I];
        mag2_d     = mag_full[OUT_W-1:0];
    end

    // S3: round, detect overflow (including rounding carry), apply sign, pick specials
    always_comb begin
        inc     = (ROUND != 0) && guard2_q && (sticky2_q || mag2_q[0]);
        sum     = {1'b0, mag2_q} + (OUT_W+1)'(inc);
        ovf_mag = pre_ovf2_q || (sign2_q ? (sum > MIN_MAG) : (sum > MAX_POS));
        res_data = '0;
        res_user = '0;
        unique case (cls2_q)
            ClsNan: res_user = 3'b100;
            ClsInf: begin
                res_data = sign2_q ? SAT_NEG : SAT_POS;
                res_user = 3'b010;
            end
            default: begin
                if (ovf_mag) begin
                    res_data = sign2_q ? SAT_NEG : SAT_POS;
                    res_user = 3'b010;
                end else begin
                    res_data = sign2_q ? -sum[OUT_W-1:0] : sum[OUT_W-1:0];
                    res_user = {2'b00, guard2_q | sticky2_q};
                end
            end
        endcase
    end

    // Valid bits and output registers: reset wins over advance
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= '0;
        end else if (advance) begin
            v1_q     <= s_axis_a_tvalid;
            v2_q     <= v1_q;
            tvalid_q <= v2_q;
            tdata_q  <= v2_q ? res_data : '0;
            tuser_q  <= v2_q ? res_user : 3'b000;
        end
    end

    // Datapath stage registers; contents are don't-care while their valid is low
    always_ff @(posedge aclk) begin
        if (advance) begin
            sign1_q    <= sign1_d;
            cls1_q     <= cls1_d;
            zero1_q    <= zero1_d;
            sub_nz1_q  <= sub_nz1_d;
            sig1_q     <= sig1_d;
            shift1_q   <= shift1_d;
            sign2_q    <= sign1_q;
            cls2_q     <= cls1_q;
            mag2_q     <= mag2_d;
            guard2_q   <= guard2_d;
            sticky2_q  <= sticky2_d;
            pre_ovf2_q <= pre_ovf2_d;
        end
    end

endmodule

// File: doc/float_to_fixed_pipe.md
# float_to_fixed_pipe

Parametrised, synthesizable floating-point to signed fixed-point converter with AXI-Stream handshakes and a fixed 3-stage pipeline. It converts any IEEE-754-style binary format (exponent/mantissa widths set by parameter) into a two's-complement fixed-point word with configurable integer/fraction split. Rounding is selectable, saturation is explicit, and per-sample status flags are produced. It sits in the datapath between float producers (FP units, host-loaded coefficients) and fixed-point consumers.

## Interface
- EXP_W, 11, float exponent width; bias = 2^(EXP_W-1)-1
- MAN_W, 52, float stored-mantissa width (hidden bit implicit)
- OUT_W, 64, fixed output width, signed two's complement
- FRAC_W, 0, fractional bits of output (0 <= FRAC_W < OUT_W)
- ROUND, 1, 0 = truncate toward zero, 1 = round-to-nearest-even
- Ports: one clock; reset is synchronous and active-low.
- aclk  in  1  clock, all state on rising edge
- aresetn  in  1  synchronous active-low reset
- s_axis_a_tdata  in  1+EXP_W+MAN_W  float input {sign, exp, man}
- s_axis_a_tvalid  in  1  input valid
- s_axis_a_tready  out  1  input ready
- m_axis_result_tdata  out  OUT_W  fixed-point result
- m_axis_result_tuser  out  3  flags {nan, ovf, inexact}
- m_axis_result_tvalid  out  1  result valid
- m_axis_result_tready  in  1  downstream ready

## Operation
- Value = (-1)^s * 1.man * 2^(exp-bias); result = round(value * 2^FRAC_W), range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- S1 (unpack/classify): split fields; classify zero, subnormal, normal, inf, NaN; compute signed shift = exp - bias + FRAC_W - MAN_W; register significand {1,man}.
- S2 (align): barrel-shift significand left or right by shift; right shifts keep guard bit and sticky (OR of all lower discarded bits); left shift beyond OUT_W marks pre-overflow.
- S3 (round/sign/saturate): ROUND=1 increments if guard & (sticky | lsb); ROUND=0 never increments; negate if sign; saturate on overflow; register outputs.
- Special cases: zero or subnormal -> 0 (subnormal with man != 0 sets inexact); NaN -> 0, nan=1; +inf -> 2^(OUT_W-1)-1, ovf=1; -inf -> -2^(OUT_W-1), ovf=1.
- Overflow: positive magnitude > 2^(OUT_W-1)-1 or negative magnitude > 2^(OUT_W-1) (including via rounding carry) -> saturate to max/min, ovf=1. Exactly -2^(OUT_W-1) is representable: no ovf.
- inexact=1 when any nonzero bits discarded (guard|sticky), independent of rounding direction; inexact=0 on saturated or NaN results.
- -0.0 -> 0, no flags.

## Timing
- Latency exactly 3 cycles: sample accepted in cycle 0 presents on outputs in cycle 3 when unstalled; throughput 1 sample/cycle.
- Global stall: advance = m_axis_result_tready | ~m_axis_result_tvalid; s_axis_a_tready = advance (combinational). All three stages shift only when advance=1; bubbles are not collapsed.
- Output tdata/tuser/tvalid held stable while tvalid=1 and tready=0.
- Transfer on input when tvalid & tready; on output when tvalid & tready. Stage valid bits follow data; invalid stages carry don't-care data.
- Reset (aresetn=0 at a rising edge): all stage valids, m_axis_result_tvalid, tdata, tuser cleared to 0; in-flight samples discarded; reset has priority over advance. s_axis_a_tready is 1 during and after reset (output not valid).
- First accept possible in the first cycle after aresetn returns high.

## Test plan
- Defaults: 0x4004000000000000 (2.5) -> 2, inexact=1; 0x400C000000000000 (3.5) -> 4, inexact=1; 0xBFF8000000000000 (-1.5) -> -2; ROUND=0 instance: 2.5 -> 2, -1.5 -> -1.
- 0x444B1AE4D6E2EF50 (1e21) -> 0x7FFFFFFFFFFFFFFF, ovf=1; 0xC3E0000000000000 (-2^63) -> 0x8000000000000000, flags 0; 0xFFF0000000000000 (-inf) -> 0x8000000000000000, ovf=1.
- 0x7FF8000000000000 (NaN) -> 0, nan=1; 0x0000000000000001 (subnormal) -> 0, inexact=1; 0x8000000000000000 -> 0, flags 0.
- FRAC_W=16, OUT_W=32 instance: 0x3FF4000000000000 (1.25) -> 0x00014000; 0x40E0000000000000 (32768.0) -> 0x7FFFFFFF, ovf=1.
- Stream 100 random values with random tready/tvalid: order preserved, no loss/duplication, outputs stable under stall, 3-cycle latency when tready held 1, bit-exact vs reference model.
- Assert aresetn=0 for 1 cycle with 3 samples in flight -> tvalid=0, tdata=0, tuser=0 next cycle; no stale samples emerge; next accepted sample appears 3 cycles later.
